axi_spi_master: RTL and testbench
=================================

// Module: axi_spi_master
// PURPOSE
// AXI4-Lite SPI master peripheral (single-byte, full duplex, CPOL/CPHA selectable).
// Attaches as slave 4 of the SoC MMIO crossbar (SPI_BASE = 0x0000_4000, mask 0x0FFF).
// Consumes the crossbar slave-port signals. Drives sclk/mosi/cs_n pads for an external flash or sensor.
// PARAMETERS
// ADDR_WIDTH  6   AXI address bits decoded (offset = addr[ADDR_WIDTH-1:0]); upper bits ignored
// DATA_WIDTH  32  AXI data width; only 32 supported
// DIV_RESET   16  reset value of DIV register (sclk half-period in clk cycles)
// PORTS
// clk      in   1   system clock
// rst      in   1   asynchronous, active-high reset
// awaddr   in   32  write address; awprot in 3 (ignored); awvalid in 1; awready out 1
// wdata    in   32  write data; wstrb in 4; wvalid in 1; wready out 1
// bresp    out  2   always 2'b00; bvalid out 1; bready in 1
// araddr   in   32  read address; arprot in 3 (ignored); arvalid in 1; arready out 1
// rdata    out  32  read data; rresp out 2 (always 2'b00); rvalid out 1; rready in 1
// sclk out 1 SPI clock | mosi out 1 | miso in 1 (assumed already synchronous to clk) | cs_n out 1 chip select
// BEHAVIOUR
// Reset: awready=wready=bvalid=arready=rvalid=0, rdata=0; cs_n=1, mosi=0, sclk=CPOL=0; CTRL=0, DIV=DIV_RESET, RXDATA=0, busy=0, rx_valid=0.
// Register map (word offsets):
//   0x00 CTRL rw [0]enable [1]CPOL [2]CPHA [3]cs (cs_n = ~cs). Writing CPOL while idle updates sclk immediately.
//   0x04 DIV rw [15:0]; an effective value of 0 is treated as 1.
//   0x08 TXDATA wo [7:0]; starts a transfer if enable=1 and busy=0, otherwise dropped silently.
//   0x0C RXDATA ro [7:0]; a read clears rx_valid.
//   0x10 STATUS ro [0]busy [1]rx_valid.
//   Unmapped reads return 0. Unmapped writes are ignored. Both respond OKAY.
// wstrb: per-byte enables apply to CTRL/DIV. A TXDATA write requires wstrb[0]; without it the write is ignored.
// Write channel:
//   Accept only when awvalid && wvalid && !bvalid. awready and wready pulse together for 1 cycle.
//   The register update occurs on that same edge. bvalid rises the next cycle and holds until bready.
// Read channel:
//   Accept when arvalid && !rvalid. arready pulses for 1 cycle.
//   rvalid and rdata are registered the next cycle and held stable until rready.
// Write and read may complete in the same cycle. If both touch RXDATA/STATUS, the read sees pre-write state.
// SPI FSM, IDLE -> XFER -> DONE -> IDLE:
//   IDLE: busy=0.
//     On TXDATA accept: shifter<=byte, edge_cnt<=0, div_cnt<=0, busy<=1 -> XFER.
//     mosi<=byte[7] at once (effective for CPHA=0).
//   XFER: div_cnt counts 0..DIV-1. At DIV-1: toggle sclk, edge_cnt++, div_cnt<=0.
//     Odd edges (1,3,..15) are leading, even edges (2..16) are trailing.
//     CPHA=0: sample miso on leading edges; shift and drive the next MSB on trailing edges.
//     CPHA=1: drive the MSB on leading edges; sample on trailing edges.
//     After edge 16 -> DONE. sclk has returned to CPOL.
//   DONE (1 cycle): RXDATA<=received byte, rx_valid<=1, busy<=0 -> IDLE.
//   Transfer length = 16*DIV + 1 clk cycles from accept edge to busy=0.
// DIV is sampled at transfer start; later writes take effect on the next transfer.
// CTRL.enable cleared mid-XFER: abort.
//   Return to IDLE next cycle, sclk<=CPOL, busy<=0, RXDATA unchanged, rx_valid unchanged.
// cs_n is purely software controlled and is not touched by the FSM.
// If DONE sets rx_valid in the same cycle an RXDATA read is accepted, set wins (rx_valid=1).
// Async rst mid-transfer: all state returns to reset values immediately, and cs_n=1.
// TESTING
// 1 Reset: assert rst mid-transfer -> cs_n=1, sclk=0, busy=0, bvalid=rvalid=0 within the same cycle.
// 2 Mode 0 loopback: DIV=2, CTRL=0x9, miso tied to mosi, write TXDATA=0xA5.
//   -> 16 sclk edges, 8 periods of 4 clk; busy high for 33 cycles; RXDATA=0xA5; STATUS=0x2.
// 3 Mode 3 with external model: CPOL=CPHA=1, DIV=1, slave returns 0x3C, TX 0xC3.
//   -> sclk idles 1, MOSI bits 1,1,0,0,0,0,1,1; RXDATA=0x3C.
// 4 Busy drop: write TXDATA 0x11 then 0x22 while busy.
//   -> only 0x11 is shifted out; bresp=OKAY for both writes.
// 5 AXI stress: hold bready/rready low 10 cycles; aw before w by 3 cycles.
//   -> bvalid/rvalid/rdata stable; single accept per transaction; unmapped 0x3C reads 0.
// 6 Abort: clear enable after edge 5 -> busy=0 next cycle, sclk=CPOL, RXDATA keeps prior value.

Source files
------------

// File: rtl/axi_spi_master_if.sv
// AXI4-Lite slave-port bundle from the MMIO crossbar to the SPI master peripheral.
interface axi_spi_master_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_spi_master.sv
// AXI4-Lite SPI master: single-byte full-duplex transfers with selectable CPOL/CPHA,
// programmable sclk half-period and software-driven chip select.
module axi_spi_master #(
    parameter int          ADDR_WIDTH = 6,
    parameter int          DATA_WIDTH = 32,
    parameter logic [15:0] DIV_RESET  = 16'd16
) (
    input  logic            clk,
    input  logic            rst,
    axi_spi_master_if.slave bus,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic            cs_n
);
    localparam int AW = ADDR_WIDTH - 2;
    localparam logic [AW-1:0] REG_CTRL   = AW'(0);
    localparam logic [AW-1:0] REG_DIV    = AW'(1);
    localparam logic [AW-1:0] REG_TX     = AW'(2);
    localparam logic [AW-1:0] REG_RX     = AW'(3);
    localparam logic [AW-1:0] REG_STATUS = AW'(4);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          state, state_next;
    logic [3:0]      ctrl;
    logic [15:0]     div, div_lat, div_cnt, div_eff;
    logic [7:0]      rx_data, tx_shift, rx_shift;
    logic            rx_valid;
    logic [4:0]      edge_cnt;
    logic [AW-1:0]   wr_word, rd_word;
    logic [DATA_WIDTH-1:0] rd_val;
    logic            wr_go, rd_go, wr_ctrl, wr_div, tx_start, rd_rx;
    logic            cpol_next, tick, leading, abort;
    logic            busy, do_sample, do_drive, finish;
    logic            unused_bits;

    assign wr_word   = bus.awaddr[ADDR_WIDTH-1:2];
    assign rd_word   = bus.araddr[ADDR_WIDTH-1:2];
    assign wr_go     = bus.awvalid && bus.wvalid && !bus.bvalid && !bus.awready;
    assign rd_go     = bus.arvalid && !bus.rvalid && !bus.arready;
    assign wr_ctrl   = wr_go && (wr_word == REG_CTRL);
    assign wr_div    = wr_go && (wr_word == REG_DIV);
    assign tx_start  = wr_go && (wr_word == REG_TX) && bus.wstrb[0] && ctrl[0] && (state == IDLE);
    assign rd_rx     = rd_go && (rd_word == REG_RX);
    assign cpol_next = (wr_ctrl && bus.wstrb[0]) ? bus.wdata[1] : ctrl[1];

    assign div_eff   = (div_lat == 16'd0) ? 16'd1 : div_lat;
    assign tick      = (state == XFER) && ctrl[0] && (div_cnt == div_eff - 16'd1);
    assign leading   = !edge_cnt[0];
    assign abort     = (state == XFER) && !ctrl[0];

    assign cs_n      = ~ctrl[3];
    assign bus.bresp = 2'b00;
    assign bus.rresp = 2'b00;

    assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[31:ADDR_WIDTH], bus.awaddr[1:0],
                           bus.araddr[31:ADDR_WIDTH], bus.araddr[1:0], bus.wdata[31:16], bus.wstrb[3:2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_start) state_next = XFER;
            XFER:    if (!ctrl[0]) state_next = IDLE;
                     else if (tick && edge_cnt == 5'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // CPHA flips which half of each sclk period samples and which drives.
    always_comb begin
        busy      = 1'b0;
        do_sample = 1'b0;
        do_drive  = 1'b0;
        finish    = 1'b0;
        case (state)
            XFER: begin
                busy      = 1'b1;
                do_sample = tick && (leading != ctrl[2]);
                do_drive  = tick && (leading == ctrl[2]);
            end
            DONE: begin
                busy   = 1'b1;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            tx_shift <= 8'h00;
            rx_shift <= 8'h00;
            edge_cnt <= 5'd0;
            div_cnt  <= 16'd0;
            div_lat  <= DIV_RESET;
        end else begin
            if (tx_start) begin
                tx_shift <= bus.wdata[7:0];
                mosi     <= bus.wdata[7];
                edge_cnt <= 5'd0;
                div_cnt  <= 16'd0;
                div_lat  <= div;
            end else if (tick) begin
                edge_cnt <= edge_cnt + 5'd1;
                div_cnt  <= 16'd0;
            end else if (state == XFER) begin
                div_cnt  <= div_cnt + 16'd1;
            end

            if (state == IDLE)  sclk <= cpol_next;
            else if (abort)     sclk <= ctrl[1];
            else if (tick)      sclk <= ~sclk;

            if (do_sample) rx_shift <= {rx_shift[6:0], miso};
            if (do_drive) begin
                mosi     <= ctrl[2] ? tx_shift[7] : tx_shift[6];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    // A completing transfer outranks a same-edge RXDATA read clearing rx_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= 4'h0;
            div      <= DIV_RESET;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            if (wr_ctrl && bus.wstrb[0]) ctrl <= bus.wdata[3:0];
            if (wr_div && bus.wstrb[0])  div[7:0]  <= bus.wdata[7:0];
            if (wr_div && bus.wstrb[1])  div[15:8] <= bus.wdata[15:8];
            if (finish) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (rd_word)
            REG_CTRL:   rd_val[3:0]  = ctrl;
            REG_DIV:    rd_val[15:0] = div;
            REG_RX:     rd_val[7:0]  = rx_data;
            REG_STATUS: rd_val[1:0]  = {rx_valid, busy};
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
        end else begin
            bus.awready <= wr_go;
            bus.wready  <= wr_go;
            if (bus.awready)                  bus.bvalid <= 1'b1;
            else if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            bus.arready <= rd_go;
            if (rd_go) bus.rdata <= rd_val;
            if (bus.arready)                  bus.rvalid <= 1'b1;
            else if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_spi_master.sv
// Directed bench for axi_spi_master: register table, SPI modes 0/3, busy drop,
// AXI back-pressure, abort and asynchronous reset mid-transfer.
module tb_axi_spi_master;
    logic clk = 1'b0;
    logic rst;
    logic sclk, mosi, miso, cs_n;
    logic loopback;
    logic miso_model;
    logic [7:0] slave_byte;
    int   neg_cnt = 0;
    int   neg_base;
    logic [7:0] cap = 8'h00;
    int   cap_cnt = 0;
    int   sclk_edges = 0;
    time  edge_t[$];
    time  aw_t = 0;
    int   aw_pulses = 0;
    int   ar_pulses = 0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    axi_spi_master_if bus ();

    axi_spi_master #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .DIV_RESET(16'd16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : miso_model;

    always @(sclk) begin
        edge_t.push_back($time);
        sclk_edges++;
    end

    always @(posedge sclk) begin
        cap = {cap[6:0], mosi};
        cap_cnt++;
    end

    // Slave model presents its next bit on each falling sclk.
    always @(negedge sclk) begin
        miso_model = slave_byte[3'(7 - (neg_cnt - neg_base))];
        neg_cnt++;
    end

    always @(posedge bus.awready) aw_t = $time;

    always @(negedge clk) begin
        if (bus.awready) aw_pulses++;
        if (bus.arready) ar_pulses++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got no handshake, expected one within bound", name);
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        if (!bus.awready) timeoutFail("aw_timeout");
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bus.bvalid) timeoutFail("b_timeout");
        else checkOutput("bresp", 32'(bus.bresp), 32'h0);
        @(negedge clk);
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data);
        int n;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
        bus.arvalid = 1'b0;
        if (!bus.arready) timeoutFail("ar_timeout");
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        if (!bus.rvalid) timeoutFail("r_timeout");
        data = bus.rdata;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] got;
        if (v.wr) axiWrite(v.addr, v.data, v.strb);
        else begin
            axiRead(v.addr, got);
            checkOutput(v.name, got, v.exp);
        end
    endtask

    task automatic waitIdle(output logic [31:0] st);
        int n;
        n = 0;
        do begin axiRead(32'h10, st); n++; end while (st[0] && n < 80);
        if (st[0]) timeoutFail("busy_timeout");
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] got, st;
        int          base_e, base_c, base_aw, base_ar, hold, n;
        logic [31:0] first_rd;

        rst = 1'b1; loopback = 1'b1; miso_model = 1'b0; slave_byte = 8'h00; neg_base = 0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 32'h0,    "rst_ctrl"});
        vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'h10,   "rst_div"});
        vecs.push_back('{1'b0, 32'h0C, 32'h0, 4'h0, 32'h0,    "rst_rxdata"});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'h0,    "rst_status"});
        vecs.push_back('{1'b1, 32'h04, 32'h0000_1234, 4'hF, 32'h0, "wr_div"});
        vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'h1234, "div_full"});
        vecs.push_back('{1'b1, 32'h04, 32'hFFFF_ABCD, 4'h1, 32'h0, "wr_div_lo"});
        vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'h12CD, "div_lo_strb"});
        vecs.push_back('{1'b1, 32'h04, 32'h0000_5600, 4'h2, 32'h0, "wr_div_hi"});
        vecs.push_back('{1'b0, 32'h4004, 32'h0, 4'h0, 32'h56CD, "div_hi_alias"});
        vecs.push_back('{1'b1, 32'h00, 32'hFFFF_FFFF, 4'hE, 32'h0, "wr_ctrl_nostrb"});
        vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 32'h0,    "ctrl_nostrb"});
        vecs.push_back('{1'b1, 32'h00, 32'h0000_00F6, 4'h1, 32'h0, "wr_ctrl"});
        vecs.push_back('{1'b0, 32'h00, 32'h0, 4'h0, 32'h6,    "ctrl_mask"});
        vecs.push_back('{1'b1, 32'h08, 32'h0000_00A5, 4'hF, 32'h0, "wr_tx_disabled"});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'h0, 32'h0,    "tx_dropped"});
        vecs.push_back('{1'b1, 32'h3C, 32'h0000_DEAD, 4'hF, 32'h0, "wr_unmapped"});
        vecs.push_back('{1'b0, 32'h3C, 32'h0, 4'h0, 32'h0,    "rd_unmapped_3c"});
        vecs.push_back('{1'b0, 32'h04, 32'h0, 4'h0, 32'h56CD, "div_after_unmapped"});
        vecs.push_back('{1'b0, 32'h14, 32'h0, 4'h0, 32'h0,    "rd_unmapped_14"});
        vecs.push_back('{1'b1, 32'h00, 32'h0, 4'hF, 32'h0,    "wr_ctrl_clear"});

        repeat (3) @(negedge clk);
        checkOutput("rst_cs_n",  32'(cs_n), 32'h1);
        checkOutput("rst_sclk",  32'(sclk), 32'h0);
        checkOutput("rst_mosi",  32'(mosi), 32'h0);
        checkOutput("rst_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
        checkOutput("rst_valid", 32'({bus.bvalid, bus.rvalid}), 32'h0);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

        // Mode 0 loopback, DIV=2.
        axiWrite(32'h04, 32'h2, 4'hF);
        axiWrite(32'h00, 32'h9, 4'hF);
        checkOutput("m0_cs_n", 32'(cs_n), 32'h0);
        loopback = 1'b1;
        base_e = sclk_edges; base_c = cap_cnt;
        axiWrite(32'h08, 32'hA5, 4'h1);
        checkOutput("m0_mosi_first", 32'(mosi), 32'h1);
        axiRead(32'h10, st);
        checkOutput("m0_busy_set", st, 32'h1);
        waitIdle(st);
        checkOutput("m0_status_done", st, 32'h2);
        checkOutput("m0_edges", 32'(sclk_edges - base_e), 32'd16);
        if (sclk_edges - base_e >= 16) begin
            checkOutput("m0_first_edge_delay", 32'(edge_t[base_e] - aw_t), 32'd20);
            checkOutput("m0_edge_span", 32'(edge_t[base_e + 15] - edge_t[base_e]), 32'd300);
        end
        checkOutput("m0_sclk_idle", 32'(sclk), 32'h0);
        checkOutput("m0_mosi_bits", 32'(cap), 32'hA5);
        checkOutput("m0_mosi_count", 32'(cap_cnt - base_c), 32'd8);
        axiRead(32'h0C, got);
        checkOutput("m0_rxdata", got, 32'hA5);
        axiRead(32'h10, st);
        checkOutput("m0_rxvalid_clr", st, 32'h0);

        // Mode 3 with external slave, DIV=1.
        loopback = 1'b0;
        slave_byte = 8'h3C;
        axiWrite(32'h04, 32'h1, 4'hF);
        axiWrite(32'h00, 32'hF, 4'hF);
        checkOutput("m3_sclk_idle_hi", 32'(sclk), 32'h1);
        neg_base = neg_cnt; base_c = cap_cnt;
        axiWrite(32'h08, 32'hC3, 4'h1);
        waitIdle(st);
        checkOutput("m3_mosi_bits", 32'(cap), 32'hC3);
        checkOutput("m3_mosi_count", 32'(cap_cnt - base_c), 32'd8);
        checkOutput("m3_sclk_end", 32'(sclk), 32'h1);
        axiRead(32'h0C, got);
        checkOutput("m3_rxdata", got, 32'h3C);

        // Busy drop with DIV=0 (effective 1).
        loopback = 1'b1;
        axiWrite(32'h04, 32'h0, 4'hF);
        axiWrite(32'h00, 32'h9, 4'hF);
        base_e = sclk_edges; base_c = cap_cnt;
        axiWrite(32'h08, 32'h11, 4'h1);
        axiWrite(32'h08, 32'h22, 4'h1);
        waitIdle(st);
        repeat (40) @(negedge clk);
        checkOutput("drop_edges", 32'(sclk_edges - base_e), 32'd16);
        checkOutput("drop_mosi_bits", 32'(cap), 32'h11);
        axiRead(32'h0C, got);
        checkOutput("drop_rxdata", got, 32'h11);

        // AXI back-pressure: aw leads w by 3 cycles, bready/rready low for 10 cycles.
        base_aw = aw_pulses; base_ar = ar_pulses;
        bus.bready = 1'b0; bus.awaddr = 32'h04; bus.wdata = 32'h0077; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1;
        repeat (3) @(negedge clk);
        bus.wvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        hold = 0;
        repeat (10) begin
            if (bus.bvalid && bus.bresp == 2'b00) hold++;
            @(negedge clk);
        end
        checkOutput("stress_bvalid_hold", 32'(hold), 32'd10);
        bus.bready = 1'b1;
        @(negedge clk);
        checkOutput("stress_bvalid_clr", 32'(bus.bvalid), 32'h0);
        checkOutput("stress_aw_accepts", 32'(aw_pulses - base_aw), 32'd1);
        bus.rready = 1'b0; bus.araddr = 32'h04; bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        first_rd = bus.rdata;
        checkOutput("stress_rdata", first_rd, 32'h77);
        hold = 0;
        repeat (10) begin
            if (bus.rvalid && bus.rdata == 32'h77) hold++;
            @(negedge clk);
        end
        checkOutput("stress_rvalid_hold", 32'(hold), 32'd10);
        bus.rready = 1'b1;
        @(negedge clk);
        checkOutput("stress_rvalid_clr", 32'(bus.rvalid), 32'h0);
        checkOutput("stress_ar_accepts", 32'(ar_pulses - base_ar), 32'd1);

        // Abort: TXDATA write and STATUS read accepted together, then enable cleared after edge 5.
        axiWrite(32'h04, 32'h4, 4'hF);
        base_e = sclk_edges;
        bus.awaddr = 32'h08; bus.wdata = 32'h5A; bus.wstrb = 4'h1;
        bus.araddr = 32'h10;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        checkOutput("same_cycle_status", bus.rdata, 32'h0);
        @(negedge clk);
        n = 0;
        while (sclk_edges - base_e < 5 && n < 200) begin @(negedge clk); n++; end
        if (sclk_edges - base_e < 5) timeoutFail("abort_edge5_timeout");
        axiWrite(32'h00, 32'h8, 4'hF);
        checkOutput("abort_sclk", 32'(sclk), 32'h0);
        axiRead(32'h10, st);
        checkOutput("abort_status", st, 32'h0);
        repeat (20) @(negedge clk);
        checkOutput("abort_edges", 32'(sclk_edges - base_e), 32'd6);
        axiRead(32'h0C, got);
        checkOutput("abort_rxdata_kept", got, 32'h11);

        // Asynchronous reset mid-transfer with pending bvalid and rvalid.
        axiWrite(32'h04, 32'h8, 4'hF);
        axiWrite(32'h00, 32'hB, 4'hF);
        axiWrite(32'h08, 32'hFF, 4'h1);
        repeat (20) @(negedge clk);
        bus.bready = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 32'h3C; bus.wdata = 32'h0; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h00; bus.arvalid = 1'b1;
        repeat (3) @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checkOutput("pre_rst_valids", 32'({bus.bvalid, bus.rvalid}), 32'h3);
        checkOutput("pre_rst_mosi", 32'(mosi), 32'h1);
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_cs_n", 32'(cs_n), 32'h1);
        checkOutput("arst_sclk", 32'(sclk), 32'h0);
        checkOutput("arst_mosi", 32'(mosi), 32'h0);
        checkOutput("arst_valids", 32'({bus.bvalid, bus.rvalid}), 32'h0);
        bus.bready = 1'b1; bus.rready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        axiRead(32'h10, st);
        checkOutput("post_rst_status", st, 32'h0);
        axiRead(32'h00, got);
        checkOutput("post_rst_ctrl", got, 32'h0);
        axiRead(32'h04, got);
        checkOutput("post_rst_div", got, 32'h10);
        axiRead(32'h0C, got);
        checkOutput("post_rst_rxdata", got, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
